// File: rtl/time_keeper_pkg.sv
// Shared types and constants for the time_keeper block.
//   bcd_t          : one BCD digit (4 bit)
//   SEC_MAX        : last second value before the minute rolls over
//   MIN_TENS_MAX   : highest legal minute tens digit
//   HOUR_MAX_TENS  : highest legal hour tens digit (24 h clock)
//   HOUR_MAX_ONES_AT_2 : highest hour ones digit when hour tens is 2
//   bcd_time_valid : range check applied to a user load request
package time_keeper_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [5:0] SEC_MAX            = 6'd59;
  localparam bcd_t       BCD_MAX            = 4'd9;
  localparam bcd_t       MIN_TENS_MAX       = 4'd5;
  localparam bcd_t       HOUR_MAX_TENS      = 4'd2;
  localparam bcd_t       HOUR_MAX_ONES_AT_2 = 4'd3;

  function automatic logic bcd_time_valid(bcd_t hr_tens, bcd_t hr_ones,
                                          bcd_t mn_tens, bcd_t mn_ones);
    logic hr_ok;
    hr_ok = (hr_tens == HOUR_MAX_TENS) ? (hr_ones <= HOUR_MAX_ONES_AT_2)
                                       : (hr_ones <= BCD_MAX);
    return (mn_tens <= MIN_TENS_MAX) && (mn_ones <= BCD_MAX) &&
           (hr_tens <= HOUR_MAX_TENS) && hr_ok;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Control/status bundle between the time_keeper and its user.
//   master : drives run_en, set_load, set_* digits; observes time and status
//   slave  : the time_keeper side
// Digits: first = minute ones, second = minute tens, third = hour ones,
// fourth = hour tens. refresh selects the digit being scanned.
interface time_keeper_if;
  import time_keeper_pkg::*;

  logic       run_en;
  logic       set_load;
  bcd_t       set_first, set_second, set_third, set_fourth;
  bcd_t       first, second, third, fourth;
  logic [1:0] refresh;
  logic       sec_tick;
  logic       colon;
  logic       load_err;

  modport master (
    output run_en, set_load, set_first, set_second, set_third, set_fourth,
    input  first, second, third, fourth, refresh, sec_tick, colon, load_err
  );

  modport slave (
    input  run_en, set_load, set_first, set_second, set_third, set_fourth,
    output first, second, third, fourth, refresh, sec_tick, colon, load_err
  );

endinterface

// File: rtl/time_keeper_bcd_digit_counter.sv
// Two-digit BCD counter (ones/tens) with a programmable wrap point.
// Counts up on inc_i; the ones digit wraps at 9 except when tens is at
// TENS_MAX, where it wraps at ONES_MAX_AT_TOP and the pair returns to 00.
//   clk, rst_n          : clock, async active-low reset (pair -> 00)
//   inc_i               : advance by one
//   load_i, load_*_i    : parallel load, wins over inc_i
//   ones_o, tens_o      : registered digits
//   carry_o             : high when this inc_i wraps the pair to 00
module time_keeper_bcd_digit_counter
  import time_keeper_pkg::*;
#(
  parameter bcd_t TENS_MAX        = 4'd5,
  parameter bcd_t ONES_MAX_AT_TOP = 4'd9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic load_i,
  input  bcd_t load_ones_i,
  input  bcd_t load_tens_i,
  output bcd_t ones_o,
  output bcd_t tens_o,
  output logic carry_o
);

  bcd_t ones_q, ones_d, tens_q, tens_d;
  logic at_top, ones_wrap;

  always_comb begin
    at_top    = (tens_q == TENS_MAX);
    ones_wrap = at_top ? (ones_q == ONES_MAX_AT_TOP) : (ones_q == BCD_MAX);
    carry_o   = inc_i && !load_i && at_top && ones_wrap;
    ones_d    = ones_q;
    tens_d    = tens_q;
    if (load_i) begin
      ones_d = load_ones_i;
      tens_d = load_tens_i;
    end else if (inc_i) begin
      if (ones_wrap) begin
        ones_d = '0;
        tens_d = at_top ? '0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= '0;
      tens_q <= '0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
    end
  end

  assign ones_o = ones_q;
  assign tens_o = tens_q;

endmodule

// File: rtl/time_keeper.sv
// Timekeeping stage for the 4-digit display mux: 1 Hz prescaler, HH:MM
// BCD time of day (24 h), user time load with range check, and the
// free-running digit-scan counter.
//   clk, rst_n : clock, async active-low reset (everything -> 0)
//   tk (slave) : run_en / set_load / set_* in; digits, refresh,
//                sec_tick, colon, load_err out (all registered)
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_BITS = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  time_keeper_if.slave tk
);

  localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [5:0]              sec_q, sec_d;
  logic [REFRESH_BITS-1:0] scan_q;
  logic                    sec_tick_q, colon_q, colon_d, load_err_q;
  logic                    load_ok, load_bad, wrap, tick, min_inc, hr_inc;
  logic                    hr_carry_unused;
  bcd_t                    mn_ones, mn_tens, hr_ones, hr_tens;

  always_comb begin
    load_ok  = tk.set_load &&  bcd_time_valid(tk.set_fourth, tk.set_third,
                                              tk.set_second, tk.set_first);
    load_bad = tk.set_load && !bcd_time_valid(tk.set_fourth, tk.set_third,
                                              tk.set_second, tk.set_first);
    wrap     = tk.run_en && (presc_q == PRESC_TC);
    // An accepted load on the rollover cycle swallows that second.
    tick     = wrap && !load_ok;
    min_inc  = tick && (sec_q == SEC_MAX);

    presc_d  = presc_q;
    sec_d    = sec_q;
    colon_d  = colon_q;
    if (load_ok) begin
      presc_d = '0;
      sec_d   = '0;
      colon_d = 1'b0;
    end else begin
      if (tk.run_en) presc_d = wrap ? '0 : presc_q + PW'(1);
      if (tick) begin
        sec_d   = (sec_q == SEC_MAX) ? 6'd0 : sec_q + 6'd1;
        colon_d = ~colon_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sec_q      <= '0;
      scan_q     <= '0;
      sec_tick_q <= 1'b0;
      colon_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_q      <= sec_d;
      scan_q     <= scan_q + REFRESH_BITS'(1);
      sec_tick_q <= tick;
      colon_q    <= colon_d;
      load_err_q <= load_bad;
    end
  end

  time_keeper_bcd_digit_counter #(
    .TENS_MAX        (MIN_TENS_MAX),
    .ONES_MAX_AT_TOP (BCD_MAX)
  ) u_min (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (min_inc),
    .load_i      (load_ok),
    .load_ones_i (tk.set_first),
    .load_tens_i (tk.set_second),
    .ones_o      (mn_ones),
    .tens_o      (mn_tens),
    .carry_o     (hr_inc)
  );

  // 23 -> 00 wrap; the day carry has no consumer.
  time_keeper_bcd_digit_counter #(
    .TENS_MAX        (HOUR_MAX_TENS),
    .ONES_MAX_AT_TOP (HOUR_MAX_ONES_AT_2)
  ) u_hr (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (hr_inc),
    .load_i      (load_ok),
    .load_ones_i (tk.set_third),
    .load_tens_i (tk.set_fourth),
    .ones_o      (hr_ones),
    .tens_o      (hr_tens),
    .carry_o     (hr_carry_unused)
  );

  assign tk.first    = mn_ones;
  assign tk.second   = mn_tens;
  assign tk.third    = hr_ones;
  assign tk.fourth   = hr_tens;
  assign tk.refresh  = scan_q[REFRESH_BITS-1 -: 2];
  assign tk.sec_tick = sec_tick_q;
  assign tk.colon    = colon_q;
  assign tk.load_err = load_err_q;

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

  logic clk, rst_n;
  time_keeper_if tk();

  time_keeper #(.CLK_HZ(10), .REFRESH_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tk    (tk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] hhmm;
    logic        colon;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0;
  int   model_secs = 0;
  bit   model_colon = 1'b0;
  int   cyc = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int h, m;
    h = s / 3600;
    m = (s / 60) % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [15:0] dut_time();
    return {tk.fourth, tk.third, tk.second, tk.first};
  endfunction

  // Cycles since reset release; the scan counter should track this exactly.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Scoreboard consumer: every sec_tick must match the next expected time.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && tk.sec_tick) begin
      if (sbq.size() == 0) chk("spurious_tick", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("tick_time", dut_time(), e.hhmm);
        chk("tick_colon", tk.colon, e.colon);
      end
    end
    if (rst_n && tk.load_err) n_err++;
  end

  task automatic push_ticks(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      model_secs  = (model_secs + 1) % 86400;
      model_colon = !model_colon;
      e.hhmm  = to_bcd(model_secs);
      e.colon = model_colon;
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_left", sbq.size(), 0);
  endtask

  task automatic do_load(input logic [3:0] ht, ho, mt, mo, input bit ok);
    @(posedge clk); #1;
    tk.set_fourth = ht; tk.set_third = ho; tk.set_second = mt; tk.set_first = mo;
    tk.set_load = 1'b1;
    @(posedge clk); #1;
    tk.set_load = 1'b0;
    if (ok) begin
      model_secs  = ht * 36000 + ho * 3600 + mt * 600 + mo * 60;
      model_colon = 1'b0;
    end
    chk("load_time", dut_time(), to_bcd(model_secs));
    chk("load_colon", tk.colon, model_colon);
    chk("load_err", tk.load_err, !ok);
    @(posedge clk); #1;
    chk("load_err_clr", tk.load_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b1;
    tk.run_en = 1'b0; tk.set_load = 1'b0;
    tk.set_first = '0; tk.set_second = '0; tk.set_third = '0; tk.set_fourth = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_time", dut_time(), 16'h0000);
    chk("rst_misc", {tk.refresh, tk.sec_tick, tk.colon, tk.load_err}, 0);

    // First second: tick after exactly 10 enabled cycles, colon set.
    @(posedge clk); #1;
    rst_n = 1'b1;
    tk.run_en = 1'b1;
    push_ticks(1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!tk.sec_tick && n < 20);
    chk("first_tick_lat", n, 10);
    drain(20);
    tk.run_en = 1'b0;

    // 12:59 + 60 s -> 13:00
    do_load(4'd1, 4'd2, 4'd5, 4'd9, 1'b1);
    tk.run_en = 1'b1;
    push_ticks(60);
    drain(620);
    tk.run_en = 1'b0;

    // 23:59 + 60 s -> 00:00
    do_load(4'd2, 4'd3, 4'd5, 4'd9, 1'b1);
    tk.run_en = 1'b1;
    push_ticks(60);
    drain(620);
    tk.run_en = 1'b0;
    chk("midnight", dut_time(), 16'h0000);

    // Rejected loads leave 00:00 in place
    do_load(4'd2, 4'd4, 4'd0, 4'd0, 1'b0);
    do_load(4'd1, 4'd2, 4'd6, 4'd0, 1'b0);
    chk("err_pulses", n_err, 2);

    // Load coinciding with the 59th-second rollover of 08:30
    do_load(4'd0, 4'd8, 4'd3, 4'd0, 1'b1);
    tk.run_en = 1'b1;
    push_ticks(59);
    drain(610);
    repeat (9) @(posedge clk);
    #1;
    tk.set_fourth = 4'd1; tk.set_third = 4'd5; tk.set_second = 4'd4; tk.set_first = 4'd5;
    tk.set_load = 1'b1;
    @(posedge clk); #1;
    tk.set_load = 1'b0;
    model_secs  = 15 * 3600 + 45 * 60;
    model_colon = 1'b0;
    chk("coll_time", dut_time(), 16'h1545);
    chk("coll_tick", tk.sec_tick, 0);
    chk("coll_colon", tk.colon, 0);
    push_ticks(60);
    drain(620);
    tk.run_en = 1'b0;

    // Frozen: no ticks (monitor), refresh still scanning
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("refresh", tk.refresh, cyc[3:2]);
    end
    chk("frozen_time", dut_time(), 16'h1546);

    // Async reset mid-count
    tk.run_en = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_time", dut_time(), 16'h0000);
    chk("arst_misc", {tk.refresh, tk.sec_tick, tk.colon, tk.load_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tk.run_en = 1'b0;
    @(negedge clk);
    chk("post_rst_time", dut_time(), 16'h0000);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
